// File: rtl/fir_seq_mac.sv
// Time-multiplexed signed FIR: a single multiplier-accumulator is reused for TAPS cycles per sample.
// Latency: a tick in cycle T produces an out_valid pulse in cycle T+TAPS+1; idle again from T+TAPS+2.
// Backpressure: none. A tick while busy is discarded and flagged by a one-cycle sample_drop pulse.
//
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   sample_tick     - one-cycle strobe qualifying value_in
//   value_in        - signed input sample (DATA_W)
//   coef_we/addr/data - runtime coefficient write (idle only, never together with a tick)
//   value_out       - signed filtered result, held until the next result
//   out_valid       - one-cycle pulse when value_out updates
//   busy            - high while a sample is being processed
//   sample_drop     - one-cycle pulse, cycle after a tick that arrived while busy
//
// Build option: define FIR_SAT_EN to saturate the result to the signed DATA_W range;
// otherwise the result is truncated (two's-complement wrap).
module fir_seq_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int TAPS      = 8,
    parameter int ACC_W     = 40,
    parameter int OUT_SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sample_tick,
    input  logic signed [DATA_W-1:0]   value_in,
    input  logic                       coef_we,
    input  logic [$clog2(TAPS)-1:0]    coef_addr,
    input  logic signed [COEF_W-1:0]   coef_data,
    output logic signed [DATA_W-1:0]   value_out,
    output logic                       out_valid,
    output logic                       busy,
    output logic                       sample_drop
);

    localparam int AW = $clog2(TAPS);
    localparam int PW = DATA_W + COEF_W;

    // Address limit one bit wider than coef_addr so non-power-of-two TAPS can be range-checked.
    localparam logic [AW:0] TAPS_LIM = (AW+1)'(TAPS);
    localparam logic [AW-1:0] LAST_IDX = AW'(TAPS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    state_t                    r_state;
    logic signed [DATA_W-1:0]  r_x    [TAPS];
    logic signed [COEF_W-1:0]  r_coef [TAPS];
    logic signed [ACC_W-1:0]   r_acc;
    logic [AW-1:0]             r_idx;
    logic signed [DATA_W-1:0]  r_value_out;
    logic                      r_out_valid;
    logic                      r_busy;
    logic                      r_sample_drop;

    logic signed [PW-1:0]      w_prod;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_acc_next;
    logic signed [ACC_W-1:0]   w_shifted;
    logic signed [DATA_W-1:0]  w_result;
    logic                      w_coef_wr;

    assign w_prod     = r_x[r_idx] * r_coef[r_idx];
    assign w_prod_ext = {{(ACC_W-PW){w_prod[PW-1]}}, w_prod};
    assign w_acc_next = r_acc + w_prod_ext;
    // Finalisation works on the accumulator including the last product so the
    // result can be registered on the same edge that leaves the MAC state.
    assign w_shifted  = w_acc_next >>> OUT_SHIFT;

`ifdef FIR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    always_comb begin
        w_result = w_shifted[DATA_W-1:0];
        if (w_shifted > SAT_MAX) begin
            w_result = {1'b0, {(DATA_W-1){1'b1}}};
        end else if (w_shifted < SAT_MIN) begin
            w_result = {1'b1, {(DATA_W-1){1'b0}}};
        end
    end
`else
    logic w_unused_hi;

    assign w_result    = w_shifted[DATA_W-1:0];
    // Bits above DATA_W are intentionally discarded in wrap mode.
    assign w_unused_hi = ^w_shifted[ACC_W-1:DATA_W];
`endif

    // Coefficients only change between samples, so a computation never sees a mixed set.
    assign w_coef_wr = coef_we && !sample_tick && (r_state == S_IDLE)
                       && ({1'b0, coef_addr} < TAPS_LIM);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_acc         <= '0;
            r_idx         <= '0;
            r_value_out   <= '0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_sample_drop <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_x[k]    <= '0;
                r_coef[k] <= (k == 0) ? COEF_W'(1) : COEF_W'(0);
            end
        end else begin
            r_out_valid   <= 1'b0;
            r_sample_drop <= sample_tick && (r_state != S_IDLE);
            case (r_state)
                S_IDLE: begin
                    if (sample_tick) begin
                        r_x[0] <= value_in;
                        for (int k = 1; k < TAPS; k++) begin
                            r_x[k] <= r_x[k-1];
                        end
                        r_acc   <= '0;
                        r_idx   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_MAC;
                    end else if (w_coef_wr) begin
                        r_coef[coef_addr] <= coef_data;
                    end
                end
                S_MAC: begin
                    r_acc <= w_acc_next;
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == LAST_IDX) begin
                        r_value_out <= w_result;
                        r_out_valid <= 1'b1;
                        r_state     <= S_OUT;
                    end
                end
                S_OUT: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign value_out   = r_value_out;
    assign out_valid   = r_out_valid;
    assign busy        = r_busy;
    assign sample_drop = r_sample_drop;

endmodule

// File: tb/tb_fir_seq_mac.sv
`timescale 1ns/1ps
module tb_fir_seq_mac;

    localparam int DATA_W    = 16;
    localparam int COEF_W    = 16;
    localparam int TAPS      = 4;
    localparam int ACC_W     = 40;
    localparam int OUT_SHIFT = 0;
    localparam int AW        = $clog2(TAPS);

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     sample_tick;
    logic signed [DATA_W-1:0] value_in;
    logic                     coef_we;
    logic [AW-1:0]            coef_addr;
    logic signed [COEF_W-1:0] coef_data;
    logic signed [DATA_W-1:0] value_out;
    logic                     out_valid;
    logic                     busy;
    logic                     sample_drop;

    always #5 clk = ~clk;

    fir_seq_mac #(
        .DATA_W(DATA_W), .COEF_W(COEF_W), .TAPS(TAPS), .ACC_W(ACC_W), .OUT_SHIFT(OUT_SHIFT)
    ) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .value_in(value_in),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .value_out(value_out), .out_valid(out_valid), .busy(busy), .sample_drop(sample_drop)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // Filter output = sum over taps of history*coef; timing described by
    // absolute cycle numbers: accepted at T, result at T+TAPS+1, free at T+TAPS+2.
    longint m_hist [TAPS];
    longint m_coef [TAPS];
    longint m_cyc  = 0;
    longint m_free = 0;
    longint m_due  = -1;
    longint m_pend = 0;
    logic signed [DATA_W-1:0] exp_vout = '0;
    logic exp_valid = 1'b0, exp_busy = 1'b0, exp_drop = 1'b0;
    bit   chk_en = 1'b0;

    function automatic logic signed [DATA_W-1:0] finalise(input longint acc);
        longint r;
        longint mx;
        logic [DATA_W-1:0] lo;
        r  = acc >>> OUT_SHIFT;
        mx = (longint'(1) << (DATA_W-1)) - 1;
`ifdef FIR_SAT_EN
        if (r > mx) r = mx;
        else if (r < -mx - 1) r = -mx - 1;
`endif
        lo = r[DATA_W-1:0];
        return signed'(lo);
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            chk_en    = 1'b1;
            m_free    = 0;
            m_due     = -1;
            exp_vout  = '0;
            exp_valid = 1'b0;
            exp_busy  = 1'b0;
            exp_drop  = 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                m_hist[k] = 0;
                m_coef[k] = (k == 0) ? 1 : 0;
            end
        end else begin
            exp_drop = sample_tick && (m_cyc < m_free);
            if (sample_tick && m_cyc >= m_free) begin
                longint sum;
                for (int k = TAPS-1; k > 0; k--) m_hist[k] = m_hist[k-1];
                m_hist[0] = longint'(value_in);
                sum = 0;
                for (int k = 0; k < TAPS; k++) sum += m_hist[k] * m_coef[k];
                m_pend = sum;
                m_due  = m_cyc + TAPS + 1;
                m_free = m_cyc + TAPS + 2;
            end else if (coef_we && !sample_tick && m_cyc >= m_free && int'(coef_addr) < TAPS) begin
                m_coef[coef_addr] = longint'(coef_data);
            end
            exp_busy  = (m_cyc + 1) < m_free;
            exp_valid = (m_cyc + 1) == m_due;
            if (exp_valid) exp_vout = finalise(m_pend);
        end
        m_cyc++;
    end

    // Single compare process: every output, every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("value_out",   64'(value_out),   64'(exp_vout));
            check("out_valid",   64'(out_valid),   64'(exp_valid));
            check("busy",        64'(busy),        64'(exp_busy));
            check("sample_drop", 64'(sample_drop), 64'(exp_drop));
        end
    end

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wcoef(input int addr, input int data);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_data = COEF_W'(data);
        @(negedge clk);
        coef_we   = 1'b0;
    endtask

    task automatic tick(input int v);
        sample_tick = 1'b1;
        value_in    = DATA_W'(v);
        @(negedge clk);
        sample_tick = 1'b0;
        value_in    = DATA_W'($urandom);
    endtask

    // lat0 = cycles elapsed since the tick at the current negedge.
    // Returns one negedge after the result, i.e. in the first cycle a new tick is accepted.
    task automatic wait_out(input string name, input int lat0, input int exp_v);
        int lat = lat0;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(TAPS + 1));
        check(name, 64'(value_out), 64'(exp_v));
        check({name, "_model"}, 64'(exp_vout), 64'(exp_v));
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; sample_tick = 1'b0; value_in = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("reset_value_out",   64'(value_out),   0);
        check("reset_out_valid",   64'(out_valid),   0);
        check("reset_busy",        64'(busy),        0);
        check("reset_sample_drop", 64'(sample_drop), 0);

        // Passthrough after reset; second tick lands in the return-to-idle cycle.
        tick(100);
        check("busy_after_tick", 64'(busy), 1);
        wait_out("passthru_100", 1, 100);
        tick(0);
        wait_out("passthru_0", 1, 0);

        // Impulse response through loaded coefficients.
        do_reset();
        wcoef(0, 1); wcoef(1, 2); wcoef(2, 4); wcoef(3, 8);
        tick(1); wait_out("impulse_0", 1, 1);
        tick(0); wait_out("impulse_1", 1, 2);
        tick(0); wait_out("impulse_2", 1, 4);
        tick(0); wait_out("impulse_3", 1, 8);
        tick(0); wait_out("impulse_4", 1, 0);

        // Signed arithmetic.
        do_reset();
        for (int k = 0; k < TAPS; k++) wcoef(k, -1);
        tick(5); wait_out("neg_5", 1, -5);
        tick(6); wait_out("neg_11", 1, -11);
        tick(7); wait_out("neg_18", 1, -18);

        // Overflow handling of the final reduction.
        do_reset();
        wcoef(0, 2);
`ifdef FIR_SAT_EN
        tick(30000); wait_out("overflow_sat", 1, 32767);
`else
        tick(30000); wait_out("overflow_wrap", 1, -5536);
`endif

        // Drop while busy, coefficient writes while busy or with a tick are ignored.
        do_reset();
        tick(5);
        @(negedge clk);
        sample_tick = 1'b1; value_in = 16'sd9;
        @(negedge clk);
        sample_tick = 1'b0;
        check("drop_pulse", 64'(sample_drop), 1);
        coef_we = 1'b1; coef_addr = AW'(1); coef_data = 16'sd3;
        @(negedge clk);
        coef_we = 1'b0;
        wait_out("drop_result", 4, 5);
        tick(1); wait_out("coef_busy_ignored", 1, 1);
        coef_we = 1'b1; coef_addr = AW'(2); coef_data = 16'sd3;
        tick(0);
        coef_we = 1'b0;
        wait_out("coef_tick_a", 1, 0);
        tick(0); wait_out("coef_tick_b", 1, 0);

        // Reset in the middle of a computation.
        do_reset();
        wcoef(0, 3);
        tick(50);
        @(negedge clk);
        do_reset();
        for (int k = 0; k < TAPS + 3; k++) begin
            check("abort_no_valid", 64'(out_valid), 0);
            check("abort_value",    64'(value_out), 0);
            @(negedge clk);
        end
        tick(7); wait_out("after_abort", 1, 7);

        // Randomised traffic, checked every cycle by the compare process.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            sample_tick = ($urandom_range(0, 2) == 0);
            value_in    = ($urandom_range(0, 1) == 0) ? DATA_W'($urandom) : DATA_W'($urandom_range(0, 200) - 100);
            coef_we     = ($urandom_range(0, 3) == 0);
            coef_addr   = AW'($urandom);
            coef_data   = ($urandom_range(0, 1) == 0) ? COEF_W'($urandom) : COEF_W'($urandom_range(0, 20) - 10);
            rst         = ($urandom_range(0, 399) == 0);
            @(negedge clk);
        end
        rst = 1'b0; sample_tick = 1'b0; coef_we = 1'b0;
        repeat (TAPS + 4) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fir_seq_mac.md
Name: fir_seq_mac

Overview:
- Parametrised, time-multiplexed FIR filter: one signed multiplier-accumulator is reused across TAPS cycles per input sample.
- Sits between the sensor sample source (strobed by sample_tick in the clk domain) and downstream filtering/control logic.
- Adds over the previous generation: runtime-loadable coefficients, signed arithmetic, configurable depth/width, an output valid strobe, a busy/drop indication and synchronous reset.

Parameters:
DATA_W, 16, width of signed input sample and output value
COEF_W, 16, width of signed coefficient
TAPS, 8, number of taps (2..64)
ACC_W, 40, accumulator width; must be >= DATA_W+COEF_W+clog2(TAPS)
OUT_SHIFT, 0, arithmetic right shift applied to the accumulator before output (0..ACC_W-DATA_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
sample_tick  in  1  single-cycle strobe, sample on value_in is valid this cycle
value_in  in  DATA_W  signed input sample
coef_we  in  1  coefficient write enable
coef_addr  in  clog2(TAPS)  tap index to write
coef_data  in  COEF_W  signed coefficient value
value_out  out  DATA_W  signed filtered result, held until next result
out_valid  out  1  one-cycle pulse when value_out updates
busy  out  1  high while a sample is being processed
sample_drop  out  1  one-cycle pulse when a tick arrives while busy

Behaviour:
- Clock is clk; reset is rst, synchronous and active-high. All state changes occur on the rising edge of clk only; sample_tick is a level sampled on clk, never used as a clock.
- Reset: delay line all 0; coef[0]=1, coef[1..TAPS-1]=0 (passthrough); value_out=0; out_valid=0; busy=0; sample_drop=0; FSM=IDLE; accumulator=0. Reset mid-operation aborts the computation with no out_valid.
- Delay line: x[0] = newest sample. On an accepted tick: x[0]<=value_in, x[k]<=x[k-1] for k=1..TAPS-1.
- FSM states:
  - IDLE: busy=0. A tick moves to MAC with the delay line shifted, acc<=0, tap index i<=0.
  - MAC: busy=1. Each cycle acc<=acc + x[i]*coef[i] (signed, sign-extended to ACC_W), i<=i+1. After i==TAPS-1, go to OUT.
  - OUT: busy=1. value_out<=finalised result, out_valid<=1 for this one cycle, go to IDLE.
- Latency: tick in cycle T gives out_valid in cycle T+TAPS+1. The next tick is accepted from cycle T+TAPS+2 onward.
- Tick while busy=1: the sample is discarded, the delay line is untouched, and sample_drop pulses in the next cycle. A tick in the same cycle the FSM returns to IDLE is accepted.
- Coefficient writes:
  - Accepted only when busy=0 and no tick is present in the same cycle.
  - The written value is used from the next accepted sample.
  - Writes while busy, or coincident with a tick, are ignored and coef is unchanged.
  - coef_addr >= TAPS is ignored.
- Result finalisation: r = acc >>> OUT_SHIFT (arithmetic shift), then reduced to DATA_W per the optional feature below.
- Accumulator never wraps given the ACC_W constraint.

Optional Feature:
- Macro: FIR_SAT_EN.
- Defined: r is saturated to the signed DATA_W range [-2^(DATA_W-1), 2^(DATA_W-1)-1].
- Not defined: value_out = r[DATA_W-1:0] (two's-complement wrap).
- All other behaviour is identical in both cases.

Test Plan:
- Reset then tick value_in=100 -> out_valid after TAPS+1 cycles, value_out=100 (passthrough); the following tick with 0 -> value_out=0.
- TAPS=4, coef={1,2,4,8}, impulse 1 then three ticks of 0 -> value_out sequence 1,2,4,8; a fifth tick of 0 -> 0.
- TAPS=4, coef={-1,-1,-1,-1}, ticks 5,6,7 -> value_out -5,-11,-18 (signed arithmetic).
- DATA_W=16, coef[0]=2, tick 30000 -> FIR_SAT_EN defined: 32767; undefined: -5536 (wrap).
- Tick, then tick 2 cycles later -> sample_drop pulses once, the result equals the single-sample case; a coef_we issued while busy -> coef readback via the next impulse response is unchanged.
- Assert rst during MAC -> no out_valid, value_out=0, coefficients back to passthrough; the next tick 7 -> value_out=7.
